// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction timer.
// FSM encoding, LFSR setup and counter-width helper.
package reaction_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LIGHTS = 3'd1;
    localparam state_t S_DELAY  = 3'd2;
    localparam state_t S_GO     = 3'd3;
    localparam state_t S_RESULT = 3'd4;

    localparam int LFSR_W = 14;
    // Taps 14,13,12,2 as bit positions 13,12,11,1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 14'h3802;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 14'h0001;

    // Bits needed to index/count n distinct values, never below 1.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr_14_en.sv
// lfsr_14_en: 14-bit Fibonacci LFSR that advances only when en is high.
// Nonzero seed plus XOR feedback keeps it out of the all-zero lock state.
module lfsr_14_en
    import reaction_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    // Shift left, feedback enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: multi-player reaction timer with LED fill, random
// hold-off, ms counters and winner pick. REACTION_BEST_TIME_EN adds best time.
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int N_PLAYERS    = 2,
    parameter int CNT_W        = 14,
    parameter int LED_N        = 10,
    parameter int LED_STEP_MS  = 500,
    parameter int MIN_DELAY_MS = 250,
    parameter int DELAY_BITS   = 11
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N_PLAYERS-1:0]       resp,
    output logic [LED_N-1:0]           ledr,
    output logic                       go,
    output logic                       busy,
    output logic [N_PLAYERS-1:0]       done,
    output logic [N_PLAYERS-1:0]       false_start,
    output logic [N_PLAYERS*CNT_W-1:0] times,
    output logic [2:0]                 winner,
`ifdef REACTION_BEST_TIME_EN
    output logic                       winner_valid,
    output logic [CNT_W-1:0]           best_time,
    output logic                       new_best
`else
    output logic                       winner_valid
`endif
);

    localparam int PS_W  = idx_w(CLK_DIV);
    localparam int MS_W  = idx_w(LED_STEP_MS);
    localparam int ST_W  = idx_w(LED_N + 1);
    localparam int DLY_W = idx_w(MIN_DELAY_MS + (1 << DELAY_BITS));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]   presc;
    logic              tick;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;
    logic              start_q;
    logic              start_re;
    logic [N_PLAYERS-1:0] resp_q;
    logic [N_PLAYERS-1:0] resp_re;
    state_t            state;
    logic [MS_W-1:0]   ms_cnt;
    logic [ST_W-1:0]   step;
    logic [DLY_W-1:0]  dly;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic              all_done;
    logic [N_PLAYERS-1:0] done_r;
    logic [N_PLAYERS-1:0] fs_r;
    logic [N_PLAYERS-1:0][CNT_W-1:0] times_r;
    logic [2:0]        win_idx;
    logic              win_any;
    logic [CNT_W-1:0]  win_time;

    assign tick        = (presc == PS_W'(CLK_DIV - 1));
    assign start_re    = start & ~start_q;
    assign resp_re     = resp & ~resp_q;
    assign all_done    = &(done_r | resp_re);
    assign sat         = (cnt == CNT_MAX);
    assign lfsr_unused = ^lfsr;

    assign done        = done_r;
    assign false_start = fs_r;
    assign times       = times_r;
    assign go          = (state == S_GO);
    assign busy        = (state == S_LIGHTS) || (state == S_DELAY) ||
                         (state == S_GO);

    // Free-running 1 ms prescaler; tick is the enable for every timebase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    lfsr_14_en u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .q     (lfsr)
    );

    // Previous-cycle copies for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            start_q <= start;
            resp_q  <= resp;
        end
    end

    // LED bar: thermometer while filling, full during hold-off.
    always_comb begin
        ledr = '0;
        if (state == S_LIGHTS) begin
            for (int i = 0; i < LED_N; i++) begin
                ledr[i] = (ST_W'(i) < step);
            end
        end else if (state == S_DELAY) begin
            ledr = '1;
        end
    end

    // Fastest valid player, lowest index on ties.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        win_time = CNT_MAX;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (done_r[i] && !fs_r[i] && times_r[i] != CNT_MAX &&
                (!win_any || times_r[i] < win_time)) begin
                win_any  = 1'b1;
                win_idx  = 3'(i);
                win_time = times_r[i];
            end
        end
    end

    // Round sequencer: fill, hold-off, timing and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ms_cnt       <= '0;
            step         <= '0;
            dly          <= '0;
            cnt          <= '0;
            done_r       <= '0;
            fs_r         <= '0;
            times_r      <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RESULT: begin
                    if (start_re) begin
                        done_r       <= '0;
                        fs_r         <= '0;
                        times_r      <= '0;
                        winner       <= '0;
                        winner_valid <= 1'b0;
                        ms_cnt       <= '0;
                        step         <= '0;
                        state        <= S_LIGHTS;
                    end else if (state == S_RESULT) begin
                        winner       <= win_idx;
                        winner_valid <= win_any;
                    end
                end
                S_LIGHTS: begin
                    done_r <= done_r | resp_re;
                    fs_r   <= fs_r | resp_re;
                    if (all_done) begin
                        state <= S_RESULT;
                    end else if (tick) begin
                        if (ms_cnt == MS_W'(LED_STEP_MS - 1)) begin
                            ms_cnt <= '0;
                            step   <= step + 1'b1;
                            if (step == ST_W'(LED_N - 1)) begin
                                dly   <= DLY_W'(MIN_DELAY_MS) +
                                         DLY_W'(lfsr[DELAY_BITS-1:0]);
                                state <= S_DELAY;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    done_r <= done_r | resp_re;
                    fs_r   <= fs_r | resp_re;
                    if (all_done) begin
                        state <= S_RESULT;
                    end else if (dly == '0) begin
                        cnt   <= '0;
                        state <= S_GO;
                    end else if (tick) begin
                        dly <= dly - 1'b1;
                    end
                end
                S_GO: begin
                    if (tick && !sat) begin
                        cnt <= cnt + 1'b1;
                    end
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (!done_r[i] && (resp_re[i] || sat)) begin
                            done_r[i]  <= 1'b1;
                            times_r[i] <= cnt;
                        end
                    end
                    if (all_done || sat) begin
                        state <= S_RESULT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REACTION_BEST_TIME_EN
    // Best winning time across rounds; pulse when it improves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_time <= '1;
            new_best  <= 1'b0;
        end else begin
            new_best <= 1'b0;
            if (state == S_RESULT && !start_re && !winner_valid &&
                win_any && win_time < best_time) begin
                best_time <= win_time;
                new_best  <= 1'b1;
            end
        end
    end
`endif

endmodule
